// File: rtl/flipper.sv
// Flips a run of opponent pieces along one board direction, optionally placing
// the mover's own piece first; owns the board memory port while working.
`timescale 1ns/1ps
module flipper (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] s_addr_in,
    input  logic       player,
    input  logic [4:0] step_in,
    input  logic       step_sign_in,
    input  logic       place_in,
    input  logic       start,
    input  logic [1:0] data_in,
    output logic [6:0] addr_out,
    output logic       wren_o,
    output logic [1:0] data_out,
    output logic       ctrl_mem,
    output logic       done_o,
    output logic       err_o,
    output logic [3:0] flip_count_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {IDLE, PLACE, READ, CHECK, FLIP, DONE} state_t;

    state_t     state, state_next;
    logic [6:0] s_addr, cur;
    logic [4:0] step;
    logic       step_sign;
    logic [1:0] own, opp;
    logic [3:0] flip_count, flip_inc;
    logic       err;

    logic [6:0] adv_base;
    logic [4:0] adv_step;
    logic       adv_sign;
    logic [7:0] adv;
    logic       adv_bad;
    logic       enter_read;
    logic       err_set;

    // Bit 7 of the 8-bit result flags both carry above 127 and borrow below 0.
    function automatic logic [7:0] advance(input logic [6:0] base,
                                           input logic [4:0] stride,
                                           input logic       sub);
        if (sub)
            advance = {1'b0, base} - {3'b000, stride};
        else
            advance = {1'b0, base} + {3'b000, stride};
    endfunction

    // In IDLE the request has not been latched yet, so advance straight from the inputs.
    always_comb begin
        adv_base = (state == IDLE) ? s_addr_in    : cur;
        adv_step = (state == IDLE) ? step_in      : step;
        adv_sign = (state == IDLE) ? step_sign_in : step_sign;
        adv      = advance(adv_base, adv_step, adv_sign);
        adv_bad  = adv[7];
        opp      = (own == 2'b01) ? 2'b10 : 2'b01;
        flip_inc = flip_count + 4'd1;
    end

    always_comb begin
        state_next = state;
        enter_read = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (place_in) begin
                        state_next = PLACE;
                    end else if (adv_bad) begin
                        state_next = DONE;
                        err_set    = 1'b1;
                    end else begin
                        state_next = READ;
                        enter_read = 1'b1;
                    end
                end
            end
            PLACE: begin
                if (adv_bad) begin
                    state_next = DONE;
                    err_set    = 1'b1;
                end else begin
                    state_next = READ;
                    enter_read = 1'b1;
                end
            end
            READ: state_next = CHECK;
            CHECK: begin
                if (data_in == opp) begin
                    state_next = FLIP;
                end else begin
                    state_next = DONE;
                    err_set    = (data_in != own);
                end
            end
            FLIP: begin
                if (flip_inc == 4'd8 || adv_bad) begin
                    state_next = DONE;
                    err_set    = 1'b1;
                end else begin
                    state_next = READ;
                    enter_read = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        addr_out = 7'd0;
        data_out = 2'b00;
        wren_o   = 1'b0;
        ctrl_mem = 1'b0;
        done_o   = 1'b0;
        case (state)
            PLACE: begin
                addr_out = s_addr;
                data_out = own;
                wren_o   = 1'b1;
                ctrl_mem = 1'b1;
            end
            READ, CHECK: begin
                addr_out = cur;
                ctrl_mem = 1'b1;
            end
            FLIP: begin
                addr_out = cur;
                data_out = own;
                wren_o   = 1'b1;
                ctrl_mem = 1'b1;
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
        busy_o       = (state != IDLE);
        err_o        = err;
        flip_count_o = flip_count;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            s_addr     <= 7'd0;
            cur        <= 7'd0;
            step       <= 5'd0;
            step_sign  <= 1'b0;
            own        <= 2'b00;
            flip_count <= 4'd0;
            err        <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                s_addr     <= s_addr_in;
                step       <= step_in;
                step_sign  <= step_sign_in;
                own        <= player ? 2'b10 : 2'b01;
                flip_count <= 4'd0;
                err        <= err_set;
                cur        <= place_in ? s_addr_in : adv[6:0];
            end else begin
                if (enter_read)
                    cur <= adv[6:0];
                if (state == FLIP)
                    flip_count <= flip_inc;
                if (err_set)
                    err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flipper.sv
// Bench for flipper: a board memory model with one-cycle read latency and a
// write scoreboard; each scenario task checks timing and final status.
`timescale 1ns/1ps
module tb_flipper;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] s_addr_in;
    logic       player;
    logic [4:0] step_in;
    logic       step_sign_in;
    logic       place_in;
    logic       start;
    logic [1:0] rdata;
    logic [6:0] addr_out;
    logic       wren_o;
    logic [1:0] data_out;
    logic       ctrl_mem;
    logic       done_o;
    logic       err_o;
    logic [3:0] flip_count_o;
    logic       busy_o;

    logic [1:0] mem [0:127];
    logic       pre_clr, pre_we;
    logic [6:0] pre_addr;
    logic [1:0] pre_data;

    int checks = 0;
    int errors = 0;
    int ctrl_cnt = 0;
    logic [8:0] exp_q [$];

    always #5 clock = ~clock;

    flipper dut (
        .clock(clock), .reset(reset), .s_addr_in(s_addr_in), .player(player),
        .step_in(step_in), .step_sign_in(step_sign_in), .place_in(place_in),
        .start(start), .data_in(rdata), .addr_out(addr_out), .wren_o(wren_o),
        .data_out(data_out), .ctrl_mem(ctrl_mem), .done_o(done_o), .err_o(err_o),
        .flip_count_o(flip_count_o), .busy_o(busy_o)
    );

    // Board memory: synchronous write, registered read (one cycle latency).
    always @(posedge clock) begin
        if (pre_clr) begin
            for (int i = 0; i < 128; i++) mem[i] <= 2'b00;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (wren_o) begin
            mem[addr_out] <= data_out;
        end
        rdata <= mem[addr_out];
    end

    // Write scoreboard and memory-port activity counter.
    always @(negedge clock) begin
        logic [8:0] e;
        if (ctrl_mem) ctrl_cnt++;
        if (wren_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr %0d data %b, expected no write", addr_out, data_out);
            end else begin
                e = exp_q.pop_front();
                if ({addr_out, data_out} !== e) begin
                    errors++;
                    $display("FAIL write_value: got addr %0d data %b, expected addr %0d data %b",
                             addr_out, data_out, e[8:2], e[1:0]);
                end
            end
        end
    end

    task automatic clear_mem();
        @(negedge clock); pre_clr = 1'b1;
        @(negedge clock); pre_clr = 1'b0;
        exp_q.delete();
    endtask

    task automatic set_cell(input logic [6:0] a, input logic [1:0] d);
        @(negedge clock); pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clock); pre_we = 1'b0;
    endtask

    // Issue one request; lat = negedges from start to the first done_o, -1 on timeout.
    task automatic do_op(input logic [6:0] a, input logic pl, input logic [4:0] st,
                         input logic sg, input logic pc, input bit poke,
                         output int lat, output int pulses);
        @(negedge clock);
        s_addr_in = a; player = pl; step_in = st; step_sign_in = sg; place_in = pc;
        start = 1'b1; ctrl_cnt = 0; lat = -1; pulses = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            if (c == 1) begin
                start = 1'b0;
                if (poke) begin
                    start = 1'b1; s_addr_in = 7'd5; place_in = 1'b1;
                    player = ~pl; step_in = 5'd3; step_sign_in = ~sg;
                end
            end
            if (c == 2) start = 1'b0;
            if (done_o) begin
                pulses++;
                if (lat < 0) lat = c;
            end
            if (lat >= 0 && c >= lat + 3) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; pre_we = 1'b0; pre_clr = 1'b1;
        pre_addr = 7'd0; pre_data = 2'b00;
        s_addr_in = 7'd0; player = 1'b0; step_in = 5'd0; step_sign_in = 1'b0; place_in = 1'b0;
        repeat (3) @(negedge clock);
        pre_clr = 1'b0;
        checks++; if (addr_out !== 7'd0 || data_out !== 2'b00) begin errors++;
            $display("FAIL reset_addr_data: got %0d/%b expected 0/00", addr_out, data_out); end
        checks++; if (wren_o !== 1'b0 || ctrl_mem !== 1'b0) begin errors++;
            $display("FAIL reset_wren_ctrl: got %b/%b expected 0/0", wren_o, ctrl_mem); end
        checks++; if (done_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b0) begin errors++;
            $display("FAIL reset_status: got done %b err %b busy %b expected 0", done_o, err_o, busy_o); end
        checks++; if (flip_count_o !== 4'd0) begin errors++;
            $display("FAIL reset_count: got %0d expected 0", flip_count_o); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (busy_o !== 1'b0) begin errors++;
            $display("FAIL idle_busy: got %b expected 0", busy_o); end
    endtask

    task automatic check_end(input string name, input int lat, input int lat_exp,
                             input int pulses, input logic err_exp, input logic [3:0] cnt_exp);
        checks++; if (lat != lat_exp) begin errors++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, lat_exp); end
        checks++; if (pulses != 1) begin errors++;
            $display("FAIL %s_done_pulses: got %0d expected 1", name, pulses); end
        checks++; if (err_o !== err_exp) begin errors++;
            $display("FAIL %s_err: got %b expected %b", name, err_o, err_exp); end
        checks++; if (flip_count_o !== cnt_exp) begin errors++;
            $display("FAIL %s_count: got %0d expected %0d", name, flip_count_o, cnt_exp); end
        checks++; if (exp_q.size() != 0) begin errors++;
            $display("FAIL %s_missing_writes: got %0d outstanding expected 0", name, exp_q.size()); end
    endtask

    task automatic test_place_flip();
        int lat, pulses;
        clear_mem();
        set_cell(7'd28, 2'b10); set_cell(7'd29, 2'b10); set_cell(7'd30, 2'b01);
        exp_q.push_back({7'd27, 2'b01}); exp_q.push_back({7'd28, 2'b01}); exp_q.push_back({7'd29, 2'b01});
        do_op(7'd27, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, lat, pulses);
        check_end("place_flip", lat, 10, pulses, 1'b0, 4'd2);
        checks++; if (mem[28] !== 2'b01 || mem[29] !== 2'b01 || mem[30] !== 2'b01) begin errors++;
            $display("FAIL place_flip_board: got %b %b %b expected 01 01 01", mem[28], mem[29], mem[30]); end
    endtask

    task automatic test_empty_end();
        int lat, pulses;
        clear_mem();
        do_op(7'd20, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, lat, pulses);
        check_end("empty_end", lat, 3, pulses, 1'b1, 4'd0);
    endtask

    task automatic test_bounds();
        int lat, pulses;
        clear_mem();
        do_op(7'd2, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, lat, pulses);
        check_end("borrow", lat, 1, pulses, 1'b1, 4'd0);
        checks++; if (ctrl_cnt != 0) begin errors++;
            $display("FAIL borrow_mem_access: got %0d cycles expected 0", ctrl_cnt); end
        exp_q.push_back({7'd120, 2'b10});
        do_op(7'd120, 1'b1, 5'd10, 1'b0, 1'b1, 1'b0, lat, pulses);
        check_end("carry", lat, 2, pulses, 1'b1, 4'd0);
        checks++; if (ctrl_cnt != 1) begin errors++;
            $display("FAIL carry_mem_access: got %0d cycles expected 1", ctrl_cnt); end
    endtask

    task automatic test_max_flips();
        int lat, pulses;
        clear_mem();
        for (int i = 1; i <= 9; i++) set_cell(7'(i), 2'b10);
        for (int i = 1; i <= 8; i++) exp_q.push_back({7'(i), 2'b01});
        do_op(7'd0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, lat, pulses);
        check_end("max_flips", lat, 25, pulses, 1'b1, 4'd8);
        checks++; if (mem[9] !== 2'b10) begin errors++;
            $display("FAIL max_flips_cell9: got %b expected 10", mem[9]); end
    endtask

    task automatic test_reset_mid();
        int lat, pulses;
        clear_mem();
        for (int i = 41; i <= 44; i++) set_cell(7'(i), 2'b10);
        set_cell(7'd45, 2'b01);
        exp_q.push_back({7'd41, 2'b01}); exp_q.push_back({7'd42, 2'b01});
        @(negedge clock);
        s_addr_in = 7'd40; player = 1'b0; step_in = 5'd1; step_sign_in = 1'b0; place_in = 1'b0;
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (5) @(negedge clock);
        checks++; if (wren_o !== 1'b1 || addr_out !== 7'd42) begin errors++;
            $display("FAIL reset_mid_second_flip: got wren %b addr %0d expected 1 42", wren_o, addr_out); end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (wren_o !== 1'b0 || ctrl_mem !== 1'b0 || busy_o !== 1'b0) begin errors++;
            $display("FAIL reset_mid_outputs: got wren %b ctrl %b busy %b expected 0", wren_o, ctrl_mem, busy_o); end
        checks++; if (flip_count_o !== 4'd0 || err_o !== 1'b0) begin errors++;
            $display("FAIL reset_mid_status: got count %0d err %b expected 0 0", flip_count_o, err_o); end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (mem[42] !== 2'b01 || mem[43] !== 2'b10 || exp_q.size() != 0) begin errors++;
            $display("FAIL reset_mid_board: got %b %b pending %0d expected 01 10 0", mem[42], mem[43], exp_q.size()); end
        set_cell(7'd51, 2'b01);
        exp_q.push_back({7'd50, 2'b01});
        do_op(7'd50, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, lat, pulses);
        check_end("after_reset", lat, 4, pulses, 1'b0, 4'd0);
    endtask

    task automatic test_start_ignored();
        int lat, pulses;
        clear_mem();
        set_cell(7'd62, 2'b01); set_cell(7'd64, 2'b10);
        exp_q.push_back({7'd62, 2'b10});
        do_op(7'd60, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, lat, pulses);
        check_end("start_ignored", lat, 6, pulses, 1'b0, 4'd1);
        checks++; if (mem[62] !== 2'b10 || mem[5] !== 2'b00) begin errors++;
            $display("FAIL start_ignored_board: got %b %b expected 10 00", mem[62], mem[5]); end
    endtask

    initial begin
        test_reset();
        test_place_flip();
        test_empty_end();
        test_bounds();
        test_max_flips();
        test_reset_mid();
        test_start_ignored();
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
